// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga pipeline.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef struct packed {
        bus32_t pc;
        bus32_t instr;
    } fetch_entry_t;

    localparam int unsigned IBUF_DEPTH_DEFAULT = 2;
    localparam bus32_t      PC_STEP            = 32'd4;

endpackage

// File: rtl/fetch_ibuf.sv
// Circular instruction buffer of {pc, instr} entries with synchronous flush.
module fetch_ibuf
    import tartaruga_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Stale storage stays hidden so an empty buffer always presents zeros.
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, fetches from instruction memory, buffers entries for decode.
module fetch_stage
    import tartaruga_pkg::*;
#(
    parameter bus32_t      RESET_PC   = 32'h0000_0000,
    parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEFAULT
) (
    input  logic   clk_i,
    input  logic   rstn_i,
    output bus32_t imem_pc_o,
    input  bus32_t imem_instr_i,
    input  logic   redirect_valid_i,
    input  bus32_t redirect_pc_i,
    input  logic   decode_ready_i,
    output logic   fetch_valid_o,
    output bus32_t fetch_pc_o,
    output bus32_t fetch_instr_o
);

    bus32_t       pc_q;
    logic         push;
    logic         pop;
    logic         ibuf_full;
    logic         ibuf_empty;
    fetch_entry_t head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // A pop frees a slot in the same cycle, so a full buffer still streams.
    assign pop  = fetch_valid_o && decode_ready_i && !redirect_valid_i;
    assign push = !redirect_valid_i && (!ibuf_full || pop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid_i) begin
            pc_q <= {redirect_pc_i[31:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    fetch_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .flush      (redirect_valid_i),
        .push       (push),
        .push_entry ('{pc: pc_q, instr: imem_instr_i}),
        .pop        (pop),
        .full       (ibuf_full),
        .empty      (ibuf_empty),
        .head       (head)
    );

    assign imem_pc_o     = pc_q;
    assign fetch_valid_o = !ibuf_empty;
    assign fetch_pc_o    = head.pc;
    assign fetch_instr_o = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        decode_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_instr = mem_word(imem_pc);

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .imem_pc_o        (imem_pc),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .decode_ready_i   (decode_ready),
        .fetch_valid_o    (fetch_valid),
        .fetch_pc_o       (fetch_pc),
        .fetch_instr_o    (fetch_instr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare(input string ctx);
        check({ctx, ".valid"}, {31'b0, fetch_valid}, {31'b0, mq.size() != 0});
        check({ctx, ".pc"},    fetch_pc,    (mq.size() != 0) ? mq[0].pc    : 32'h0);
        check({ctx, ".instr"}, fetch_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
        check({ctx, ".imem_pc"}, imem_pc, m_pc);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC;
    endtask

    // Drive one cycle of inputs, advance the model by the same cycle, then compare.
    task automatic step(input string ctx, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit do_pop;
        bit do_push;
        ent_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        decode_ready   = rdy;
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = (mq.size() < DEPTH) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk_i);
        compare(ctx);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_i);
        compare("reset");
        rstn_i = 1'b1;

        for (int i = 0; i < 8; i++) step("stream", 1'b0, '0, 1'b1);

        step("redir0", 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step("stall", 1'b0, '0, 1'b0);
        check("stall_imem_frozen", imem_pc, 32'h8);
        check("stall_head_pc", fetch_pc, 32'h0);
        for (int i = 0; i < 4; i++) step("release", 1'b0, '0, 1'b1);

        step("redir40", 1'b1, 32'h40, 1'b1);
        check("redir40_valid_low", {31'b0, fetch_valid}, 32'h0);
        step("redir40_tgt", 1'b0, '0, 1'b1);
        check("redir40_head", fetch_pc, 32'h40);
        for (int i = 0; i < 3; i++) step("post40", 1'b0, '0, 1'b1);

        for (int i = 0; i < 3; i++) step("fill", 1'b0, '0, 1'b0);
        step("misalign", 1'b1, 32'h43, 1'b0);
        check("misalign_imem_pc", imem_pc, 32'h40);
        check("misalign_empty", {31'b0, fetch_valid}, 32'h0);

        step("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1);
        step("wrap1", 1'b0, '0, 1'b1);
        check("wrap_first", fetch_pc, 32'hFFFF_FFFC);
        step("wrap2", 1'b0, '0, 1'b1);
        check("wrap_second", fetch_pc, 32'h0);
        for (int i = 0; i < 3; i++) step("wraprun", 1'b0, '0, 1'b1);

        rstn_i = 1'b0;
        #1;
        model_reset();
        compare("midreset");
        @(negedge clk_i);
        compare("midreset_hold");
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) step("restart", 1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
